// File: rtl/mainfsm.sv
// Multicycle RISC-V main control FSM.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       IllegalOp,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t cur_state, nxt_state;

  assign state = cur_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = FETCH;
    case (cur_state)
      FETCH:    nxt_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_R:         nxt_state = EXECUTER;
          OP_I:         nxt_state = EXECUTEI;
          OP_BEQ:       nxt_state = BEQ;
          OP_JAL:       nxt_state = JAL;
          OP_LUI:       nxt_state = LUI;
          default:      nxt_state = FETCH;
        endcase
      end
      MEMADR:   nxt_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt_state = MemReady ? MEMWB : MEMREAD;
      MEMWB:    nxt_state = FETCH;
      MEMWRITE: nxt_state = MemReady ? FETCH : MEMWRITE;
      EXECUTER: nxt_state = ALUWB;
      EXECUTEI: nxt_state = ALUWB;
      ALUWB:    nxt_state = FETCH;
      BEQ:      nxt_state = FETCH;
      JAL:      nxt_state = ALUWB;
      LUI:      nxt_state = FETCH;
      default:  nxt_state = FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    ALUOp     = '0;
    IllegalOp = 1'b0;
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
    case (cur_state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        IllegalOp = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI});
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB:    RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = Zero;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default:  ImmSrc = '0;
    endcase
    // Write strobes are forced low combinationally so an asserted reset aborts
    // an in-flight access without waiting for the state register to settle.
    if (reset) begin
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 Parameters: none; all encodings fixed by this document.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
REQ-004 op  input  7  opcode field of instruction register (instr[6:0]).
REQ-005 Zero  input  1  ALU zero flag, used in BEQ.
REQ-006 MemReady  input  1  memory handshake; 1 = current access completes this cycle.
REQ-007 PCWrite  output  1  PC register enable.
REQ-008 AdrSrc  output  1  memory address select (0 PC, 1 ALUOut).
REQ-009 MemWrite  output  1  memory write strobe.
REQ-010 IRWrite  output  1  instruction/OldPC register enable.
REQ-011 RegWrite  output  1  register file write enable.
REQ-012 ResultSrc  output  2  result mux (00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt).
REQ-013 ALUSrcA  output  2  SrcA mux (00 PC, 01 OldPC, 10 RD1).
REQ-014 ALUSrcB  output  2  SrcB mux (00 RD2, 01 ImmExt, 10 constant 4).
REQ-015 ALUOp  output  2  to ALU decoder (00 add, 01 subtract, 10 funct-decoded).
REQ-016 ImmSrc  output  3  immediate format select.
REQ-017 IllegalOp  output  1  unsupported opcode flag.
REQ-018 state  output  4  current state encoding, for debug/verification.

Function
REQ-019 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11; encodings 12-15 unreachable and SHALL transition to FETCH with all outputs 0.
REQ-020 Outputs are Moore (functions of state) except PCWrite, IRWrite, MemWrite, ImmSrc, IllegalOp as stated below; unlisted outputs are 0 in every state.
REQ-021 ImmSrc decodes op combinationally in every state: 0000011/0010011 -> 000, 0100011 -> 001, 1100011 -> 010, 1101111 -> 011, 0110111 -> 100, other -> 000.
REQ-022 FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10; IRWrite = PCWrite = MemReady; stay while MemReady 0, else -> DECODE.
REQ-023 DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00; next by op: lw/sw -> MEMADR, R-type 0110011 -> EXECUTER, 0010011 -> EXECUTEI, beq -> BEQ, jal -> JAL, lui -> LUI.
REQ-024 DECODE with any other op: IllegalOp = 1 that cycle only, next state FETCH, no register or memory write.
REQ-025 MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00; op 0000011 -> MEMREAD, else -> MEMWRITE.
REQ-026 MEMREAD: AdrSrc 1, ResultSrc 00; stay while MemReady 0, else -> MEMWB.
REQ-027 MEMWB: ResultSrc 01, RegWrite 1; -> FETCH.
REQ-028 MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1 held every cycle until MemReady 1; then -> FETCH.
REQ-029 EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10; -> ALUWB. EXECUTEI: same with ALUSrcB 01; -> ALUWB.
REQ-030 ALUWB: ResultSrc 00, RegWrite 1; -> FETCH.
REQ-031 BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, PCWrite = Zero; -> FETCH.
REQ-032 JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCWrite 1; -> ALUWB.
REQ-033 LUI: ResultSrc 11, RegWrite 1; -> FETCH.
REQ-034 Instruction latency with MemReady always 1: lw 5, sw 4, R/I/jal 4, beq 3, lui 3 cycles.
REQ-035 MemReady is ignored outside FETCH, MEMREAD, MEMWRITE.

Reset
REQ-036 While reset is 1: state 0 (FETCH), IRWrite/PCWrite follow MemReady per REQ-022 are gated to 0, MemWrite 0, RegWrite 0, IllegalOp 0.
REQ-037 Reset asserted mid-instruction (incl. during MEMWRITE wait) SHALL abort it: MemWrite drops asynchronously, no RegWrite follows; first cycle after release is FETCH.

Verification
REQ-038 reset 1, MemReady 1 -> state 0, all write enables 0; release -> FETCH with IRWrite 1.
REQ-039 op 0000011, MemReady 1 -> states 0,1,2,3,4,0; RegWrite 1 only in state 4 with ResultSrc 01.
REQ-040 op 0100011, MemReady 0 for 3 cycles in MEMWRITE -> MemWrite 1 for 4 cycles, then FETCH; RegWrite never 1.
REQ-041 op 1100011, Zero 1 then repeat with Zero 0 -> PCWrite 1 / 0 in BEQ; ALUOp 01 both cases.
REQ-042 op 1111111 -> IllegalOp 1 in DECODE, next state 0, no writes.
REQ-043 op 0110111 -> states 0,1,11,0; ImmSrc 100, ResultSrc 11, RegWrite 1 in state 11.
